// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift op codes, funct constants and micro-op struct (ROTATE_EN adds rotates)
package shift_pkg;

  typedef enum logic [1:0] {
    LO_L = 2'd0,
    LO_R = 2'd1,
    AL_R = 2'd2,
    CI_R = 2'd3
  } shift_op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;

  typedef struct packed {
    logic [31:0] shift_in;
    logic [4:0]  shift_amount;
    shift_op_e   shift_op;
    logic [4:0]  rd;
    logic        illegal;
  } shift_uop_t;

  // Value held by empty/illegal registers: LO_L with amount 0, nothing flagged.
  localparam shift_uop_t UOP_ZERO = '{
    shift_in:     32'd0,
    shift_amount: 5'd0,
    shift_op:     LO_L,
    rd:           5'd0,
    illegal:      1'b0
  };

endpackage

// File: rtl/shift_decode.sv
// rtl/shift_decode.sv - combinational R-type shift decode into shift_uop_t (ROTATE_EN enables ROTR/ROTRV)
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output shift_uop_t  uop
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [4:0] rs_amt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign shamt  = instr[10:6];
  assign rs_amt = rs_val[4:0];

  // Upper operand bits and the rs/rt register-number fields play no part in the micro-op.
  logic decode_unused;
  assign decode_unused = ^{rs_val[31:5], instr[25:22], instr[20:16]};

  // Default to an illegal LO_L/0 micro-op, then overwrite for each supported encoding.
  always_comb begin
    uop.shift_in     = rt_val;
    uop.rd           = instr[15:11];
    uop.shift_op     = LO_L;
    uop.shift_amount = 5'd0;
    uop.illegal      = 1'b1;
    if (opcode == OPC_SPECIAL) begin
      case (funct)
        F_SLL: begin
          uop.shift_op     = LO_L;
          uop.shift_amount = shamt;
          uop.illegal      = 1'b0;
        end
        F_SRL: begin
          if (!instr[21]) begin
            uop.shift_op     = LO_R;
            uop.shift_amount = shamt;
            uop.illegal      = 1'b0;
          end else begin
`ifdef ROTATE_EN
            uop.shift_op     = CI_R;
            uop.shift_amount = shamt;
            uop.illegal      = 1'b0;
`else
            uop.illegal      = 1'b1;
`endif
          end
        end
        F_SRA: begin
          uop.shift_op     = AL_R;
          uop.shift_amount = shamt;
          uop.illegal      = 1'b0;
        end
        F_SLLV: begin
          uop.shift_op     = LO_L;
          uop.shift_amount = rs_amt;
          uop.illegal      = 1'b0;
        end
        F_SRLV: begin
          if (!instr[6]) begin
            uop.shift_op     = LO_R;
            uop.shift_amount = rs_amt;
            uop.illegal      = 1'b0;
          end else begin
`ifdef ROTATE_EN
            uop.shift_op     = CI_R;
            uop.shift_amount = rs_amt;
            uop.illegal      = 1'b0;
`else
            uop.illegal      = 1'b1;
`endif
          end
        end
        F_SRAV: begin
          uop.shift_op     = AL_R;
          uop.shift_amount = rs_amt;
          uop.illegal      = 1'b0;
        end
        default: begin
          uop.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - registered shift issue stage with one-entry skid buffer and flush (ROTATE_EN optional)
module shift_issue_stage
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [31:0] Instr,
  input  logic [31:0] Rs_val,
  input  logic [31:0] Rt_val,
  input  logic        Flush,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Shift_in,
  output logic [4:0]  Shift_amount,
  output logic [1:0]  Shift_op,
  output logic [4:0]  Rd,
  output logic        Illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  stage_state_e state;
  shift_uop_t   dec_uop;
  shift_uop_t   out_q;
  shift_uop_t   skid_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         accept;
  logic         consume;

  shift_decode u_decode (
    .instr  (Instr),
    .rs_val (Rs_val),
    .rt_val (Rt_val),
    .uop    (dec_uop)
  );

  assign accept  = In_valid & in_ready_q;
  assign consume = out_valid_q & Out_ready;

  assign In_ready     = in_ready_q;
  assign Out_valid    = out_valid_q;
  assign Shift_in     = out_q.shift_in;
  assign Shift_amount = out_q.shift_amount;
  assign Shift_op     = out_q.shift_op;
  assign Rd           = out_q.rd;
  assign Illegal      = out_q.illegal;

  // Occupancy control: out reg first, skid only while the out reg is stalled; flush empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      out_q       <= UOP_ZERO;
      skid_q      <= UOP_ZERO;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (Flush) begin
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_q       <= dec_uop;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_q <= dec_uop;
          end else if (accept) begin
            skid_q     <= dec_uop;
            in_ready_q <= 1'b0;
            state      <= ST_TWO;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
